// File: rtl/add_accum_seq.sv
// Sequential accumulator: sums len handshaked N-bit operands via adder_carry_para; sticky carry-out flag.
// One operand per clock when din_valid is high; din_ready is high only in LOAD; result visible the cycle after each accept.

module adder_carry_para #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

module add_accum_seq #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic          din_valid,
    input  logic [N-1:0]  din,
    output logic          din_ready,
    output logic [N-1:0]  acc,
    output logic          ovf,
    output logic          busy,
    output logic          done_tick
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  add_sum;
    logic          add_cout;
    logic          accept;

    adder_carry_para #(.N(N)) u_adder (
        .a    (acc_q),
        .b    (din),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Moore outputs: decoded from state only, never from din_valid or start
    assign din_ready = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_DONE);
    assign done_tick = (state_q == ST_DONE);
    assign acc       = acc_q;
    assign ovf       = ovf_q;

    assign accept = din_valid & din_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_cout;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/add_accum_seq.md
# add_accum_seq

Sequential multi-operand accumulator built around the team's parameterized `adder_carry_para`. It sums a handshaked stream of `len` unsigned N-bit operands into a registered accumulator and flags carry-out overflow. It sits directly downstream of the adder: one `adder_carry_para #(.N(N))` instance computes `acc + din`, and this block registers the sum and carry and sequences the operands.

## Interface
- `N`, default 8: operand and accumulator width, passed to the `adder_carry_para` instance.
- `CW`, default 4: width of the operand-count field.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled in IDLE only; begins a new accumulation.
- `len`  in  CW  number of operands, sampled with `start`; range 0..2^CW-1.
- `din_valid`  in  1  operand valid.
- `din`  in  N  unsigned operand.
- `din_ready`  out  1  block accepts an operand this cycle.
- `acc`  out  N  registered running sum, modulo 2^N.
- `ovf`  out  1  sticky flag: any carry-out occurred during the current run.
- `busy`  out  1  high in LOAD and DONE.
- `done_tick`  out  1  one-cycle pulse in DONE.

## Operation
- The FSM has three states: IDLE, LOAD and DONE. The count register `cnt` is CW bits wide.
- **IDLE:**
  - `din_ready`=0, `busy`=0.
  - If `start`=1 and `len`≠0: `acc`←0, `ovf`←0, `cnt`←`len`, go to LOAD.
  - If `start`=1 and `len`=0: `acc`←0, `ovf`←0, go to DONE.
  - Otherwise hold all registers. `acc` and `ovf` keep the last result.
- **LOAD:**
  - `din_ready`=1, `busy`=1.
  - On accept (`din_valid`&`din_ready`): `acc`←sum[N-1:0] of the adder, `ovf`←`ovf`|cout, `cnt`←`cnt`-1.
  - If accepting with `cnt`=1, go to DONE; otherwise stay in LOAD.
  - With no accept, all registers hold. Gaps in `din_valid` of any length are allowed.
- **DONE:**
  - `done_tick`=1, `busy`=1, `din_ready`=0.
  - Unconditionally go to IDLE next cycle.
  - `start` is ignored here.
- `start` asserted in LOAD or DONE is ignored and is not queued.
- Arithmetic:
  - The adder sees `a`=`acc` and `b`=`din`, both N bits.
  - The result wraps modulo 2^N.
  - `ovf` only ever goes from 0 to 1 within a run and clears only on an accepted `start` or on reset.
- Reset (asynchronous, `reset_n`=0) at any time, including mid-LOAD:
  - State←IDLE, `acc`=0, `ovf`=0, `cnt`=0.
  - All outputs go to 0 immediately.
  - A partial run is discarded. There is no resume.

## Timing
- Reset values: `acc`=0, `ovf`=0, `din_ready`=0, `busy`=0, `done_tick`=0.
- `din_ready`, `busy` and `done_tick` are Moore outputs decoded from state only. There is no combinational path from `din_valid` or `start` to any output.
- Start is seen at edge k; LOAD and `din_ready`=1 apply from cycle k+1.
- An operand accepted at edge j appears in `acc` and `ovf` after edge j (visible in cycle j+1).
- Run length:
  - Back-to-back operands: `len` accept cycles plus one DONE cycle.
  - `done_tick` is high in the cycle after the final accept, and `acc` already holds the final sum in that cycle.
- `len`=0: DONE in cycle k+1, `acc`=0, `ovf`=0.
- Minimum start-to-start spacing is `len`+2 cycles. A new `start` is accepted in the IDLE cycle that follows DONE.
- Maximum throughput is one operand per clock.

## Test plan
- **Basic sum:** N=8, `len`=3, operands 10, 20, 30 back-to-back → `acc`=60, `ovf`=0. `done_tick` is a single-cycle pulse in the cycle after the 3rd accept. `busy` is high for 4 cycles.
- **Overflow:** `len`=2, operands 200, 100 → `acc`=44, `ovf`=1. On the next run (`len`=1, operand 5) → `acc`=5, `ovf`=0.
- **Valid gaps:** `len`=4, operands 1, 2, 3, 4 with `din_valid` low for 0, 3, 1 and 5 cycles between them → `acc`=10. `cnt` and `acc` are unchanged during gaps. `done_tick` occurs exactly once.
- **Zero length and ignored start:**
  - `len`=0 → `done_tick` in cycle k+1, `acc`=0, `din_ready` never high.
  - `start` pulsed in LOAD of a `len`=2 run (operands 7, 8) → result `acc`=15, and no extra run follows.
- **Reset mid-run:** `len`=5 with 2 operands accepted, then `reset_n`=0 asynchronously between edges → all outputs 0 immediately. After release, a `len`=1 run with operand 9 gives `acc`=9, `ovf`=0.
- **Wrap-around and maximum length:** CW=4, `len`=15, all operands 255 → `acc`=241 (3825 mod 256), `ovf`=1, `done_tick` after the 15th accept.
